note_lane_scheduler: RTL and testbench
======================================

NOTE_LANE_SCHEDULER -- requirements
Module: note_lane_scheduler

Interface
REQ-001 Parameter LANE_X0, default 16, x of lane 0 left column.
REQ-002 Parameter LANE_PITCH, default 32, x spacing between lanes.
REQ-003 Parameter Y_LAST, default 116, last legal top-row y of a 4x4 note.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port tick  input  1  one-cycle pulse; advance all active notes one row.
REQ-007 Port spawn  input  5  one-cycle pulses; bit i requests a new note in lane i.
REQ-008 Port x  output  8  pixel x to VGA adapter.
REQ-009 Port y  output  7  pixel y to VGA adapter.
REQ-010 Port colour  output  3  pixel colour to VGA adapter.
REQ-011 Port plot  output  1  write strobe; x, y, colour valid when high.
REQ-012 Port active  output  5  bit i high while lane i holds a note.
REQ-013 Port miss  output  1  one-cycle pulse when a note leaves the bottom.
REQ-014 Port overrun  output  1  one-cycle pulse when a tick is dropped.
REQ-015 Port busy  output  1  high in every state except IDLE.

Function
REQ-016 Per lane i: active bit, 7-bit row register ypos[i], fixed x = LANE_X0 + LANE_PITCH*i.
REQ-017 Fixed colours: lane 0 3'b010, 1 3'b100, 2 3'b110, 3 3'b001, 4 3'b101; erase colour 3'b000.
REQ-018 spawn bits OR into pending[4:0] each cycle, in every state.
REQ-019 A tick arriving while busy sets tick_pend; a tick while tick_pend already set is dropped and pulses overrun.
REQ-020 States: IDLE, SPAWN_DRAW, ERASE, STEP, DRAW, NEXT.
REQ-021 IDLE: tick or tick_pend -> clear tick_pend, lane ptr = lowest active lane, go ERASE; if no lane active, stay IDLE.
REQ-022 IDLE, no tick: pending nonzero -> select lowest set bit, clear it; if lane inactive, set active, ypos=0, go SPAWN_DRAW; if lane already active, drop request, stay IDLE.
REQ-023 Tick has priority over spawn in IDLE.
REQ-024 SPAWN_DRAW, ERASE, DRAW: 4-bit pixel counter cnt runs 0..15, one pixel per cycle, plot=1; x = lane x + cnt[1:0], y = ypos + cnt[3:2].
REQ-025 Colour: lane colour in SPAWN_DRAW and DRAW, 3'b000 in ERASE.
REQ-026 cnt==15 in SPAWN_DRAW -> IDLE; in ERASE -> STEP; in DRAW -> NEXT; cnt resets to 0 on every state exit.
REQ-027 STEP, one cycle, plot=0: ypos==Y_LAST -> clear active, pulse miss, go NEXT; else ypos+1, go DRAW.
REQ-028 NEXT, one cycle, plot=0: next higher active lane exists -> ERASE for it; else IDLE.
REQ-029 Sweep cost per active lane 34 cycles (16 erase + 1 step + 16 draw + 1 next); ypos never exceeds Y_LAST, so y never exceeds 119.
REQ-030 plot, x, y, colour are registered outputs; plot=0 in IDLE, STEP, NEXT; x, y, colour hold last value when plot=0.
REQ-031 A lane spawned mid-sweep is not included in that sweep; served after return to IDLE.

Reset
REQ-032 reset high forces immediately, regardless of clk: state IDLE, cnt 0, active 0, all ypos 0, pending 0, tick_pend 0.
REQ-033 Output values during and after reset: x 0, y 0, colour 0, plot 0, miss 0, overrun 0, busy 0.
REQ-034 Reset mid-draw aborts the sequence; no further plot pulses until a new spawn.

Verification
REQ-035 Spawn lane 0 from reset -> 16 plot cycles, x 16..19, y 0..3, colour 010; active=00001; then busy=0.
REQ-036 Lane 2 active at ypos 5, tick -> 16 plots colour 000 at x 80..83, y 5..8, then 16 plots colour 110 at y 6..9; 34 busy cycles.
REQ-037 Lane 4 active at ypos 116, tick -> erase at y 116..119, one-cycle miss, active[4]=0, no draw plots.
REQ-038 Lanes 0 and 3 active, spawn[1] and tick same cycle -> sweep lane 0 then lane 3 first, then lane 1 drawn at y 0.
REQ-039 Three ticks during one sweep -> one overrun pulse, exactly one extra sweep afterwards.
REQ-040 reset asserted at cnt=7 of a DRAW -> plot 0 and active 0 without a clk edge; spawn afterwards behaves as in REQ-035.

Source files
------------

// File: rtl/note_lane_scheduler.sv
// Five-lane falling-note scheduler: spawns, erases, steps and redraws 4x4 notes
// by streaming one pixel per cycle to a VGA adapter.
module note_lane_scheduler #(
  parameter int LANE_X0    = 16,
  parameter int LANE_PITCH = 32,
  parameter int Y_LAST     = 116
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [4:0] spawn,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [4:0] active,
  output logic       miss,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SPAWN_DRAW = 3'd1;
  localparam logic [2:0] ERASE      = 3'd2;
  localparam logic [2:0] STEP       = 3'd3;
  localparam logic [2:0] DRAW       = 3'd4;
  localparam logic [2:0] NEXT       = 3'd5;

  logic [2:0] state;
  logic [2:0] lane;
  logic [3:0] cnt;
  logic [4:0] pending;
  logic       tick_pend;
  logic [6:0] ypos [5];

  logic       tick_now;
  logic [2:0] spawn_lane;
  logic [4:0] above;
  logic [4:0] clr_mask;
  logic [6:0] cur_y;
  logic [7:0] lane_x;
  logic [2:0] lane_col;

  function automatic logic [2:0] lowest(input logic [4:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 4; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    tick_now   = tick | tick_pend;
    spawn_lane = lowest(pending);
    above      = active & (5'b11110 << lane);
    cur_y      = ypos[lane];
    lane_x     = 8'(LANE_X0 + LANE_PITCH * int'(lane));
    case (lane)
      3'd0:    lane_col = 3'b010;
      3'd1:    lane_col = 3'b100;
      3'd2:    lane_col = 3'b110;
      3'd3:    lane_col = 3'b001;
      3'd4:    lane_col = 3'b101;
      default: lane_col = 3'b000;
    endcase
    // A spawn request is consumed only when IDLE actually services it.
    clr_mask = '0;
    if (state == IDLE && !tick_now && |pending)
      clr_mask = 5'b00001 << spawn_lane;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lane      <= '0;
      cnt       <= '0;
      pending   <= '0;
      tick_pend <= 1'b0;
      active    <= '0;
      for (int i = 0; i < 5; i++) ypos[i] <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      miss      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      plot    <= 1'b0;
      miss    <= 1'b0;
      overrun <= 1'b0;
      pending <= (pending & ~clr_mask) | spawn;

      // IDLE always absorbs the tick; while busy at most one tick can wait.
      if (state == IDLE)
        tick_pend <= 1'b0;
      else if (tick) begin
        if (tick_pend) overrun <= 1'b1;
        else           tick_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick_now) begin
            if (|active) begin
              lane  <= lowest(active);
              state <= ERASE;
            end
          end else if (|pending) begin
            lane <= spawn_lane;
            if (!active[spawn_lane]) begin
              active[spawn_lane] <= 1'b1;
              ypos[spawn_lane]   <= '0;
              state              <= SPAWN_DRAW;
            end
          end
        end
        SPAWN_DRAW, ERASE, DRAW: begin
          plot   <= 1'b1;
          x      <= lane_x + 8'(cnt[1:0]);
          y      <= cur_y + 7'(cnt[3:2]);
          colour <= (state == ERASE) ? 3'b000 : lane_col;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            cnt <= '0;
            case (state)
              SPAWN_DRAW: state <= IDLE;
              ERASE:      state <= STEP;
              default:    state <= NEXT;
            endcase
          end
        end
        STEP: begin
          if (cur_y == 7'(Y_LAST)) begin
            active[lane] <= 1'b0;
            miss         <= 1'b1;
            state        <= NEXT;
          end else begin
            ypos[lane] <= cur_y + 7'd1;
            state      <= DRAW;
          end
        end
        NEXT: begin
          if (|above) begin
            lane  <= lowest(above);
            state <= ERASE;
          end else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Directed bench for note_lane_scheduler: logs every plotted pixel and compares
// against hand-built expected pixel sequences.
module tb_note_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [4:0] spawn = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [4:0] active;
  logic       miss;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int fails = 0;
  int busy_cnt = 0;
  int miss_cnt = 0;
  int ovr_cnt = 0;
  int max_y = 0;
  logic [17:0] log_q[$];
  logic [17:0] exp_q[$];

  note_lane_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .spawn(spawn),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .active(active), .miss(miss), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (plot) begin
        log_q.push_back({x, y, colour});
        if (int'(y) > max_y) max_y = int'(y);
      end
      if (busy) busy_cnt++;
      if (miss) miss_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task clear_log;
    log_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    miss_cnt = 0;
    ovr_cnt = 0;
  endtask

  // Expected 4x4 block, raster order: x varies fastest.
  task add_block(input int xb, input int yb, input logic [2:0] col);
    for (int i = 0; i < 16; i++)
      exp_q.push_back({8'(xb + i % 4), 7'(yb + i / 4), col});
  endtask

  task do_reset;
    @(negedge clk);
    reset = 1'b1;
    tick = 1'b0;
    spawn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task pulse(input logic t, input logic [4:0] s);
    @(negedge clk);
    tick = t;
    spawn = s;
    @(negedge clk);
    tick = 1'b0;
    spawn = '0;
  endtask

  task wait_idle(input string name);
    int stable;
    int n;
    stable = 0;
    n = 0;
    repeat (2) @(negedge clk);
    while (stable < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy && !plot) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 3) begin
      fails++;
      $display("[TB] FAIL %s idle timeout: busy=%b after %0d cycles, required busy=0", name, busy, n);
    end
  endtask

  task test_reset;
    reset = 1'b1;
    #2;
    checks++;
    if ({x, y, colour, plot, miss, overrun, busy, active} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_during: got x=%0d y=%0d c=%b plot=%b miss=%b ovr=%b busy=%b act=%b, required all 0",
               x, y, colour, plot, miss, overrun, busy, active);
    end
    do_reset();
    checks++;
    if ({x, y, colour, plot, miss, overrun, busy, active} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_after: got x=%0d y=%0d c=%b plot=%b busy=%b act=%b, required all 0",
               x, y, colour, plot, busy, active);
    end
    clear_log();
    pulse(1'b1, 5'b00000);
    repeat (10) @(negedge clk);
    checks++;
    if (busy_cnt != 0 || log_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL tick_no_lanes: got busy_cycles=%0d plots=%0d, required 0 and 0", busy_cnt, log_q.size());
    end
  endtask

  task test_spawn_lane0;
    do_reset();
    clear_log();
    pulse(1'b0, 5'b00001);
    wait_idle("spawn0");
    add_block(16, 0, 3'b010);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL spawn0 pixel_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL spawn0 pixel %0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (active !== 5'b00001 || busy_cnt != 16) begin
      fails++;
      $display("[TB] FAIL spawn0 state: got active=%b busy_cycles=%0d, required 00001 and 16", active, busy_cnt);
    end
    clear_log();
    pulse(1'b0, 5'b00001);
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != 0 || busy_cnt != 0) begin
      fails++;
      $display("[TB] FAIL spawn_dup: got plots=%0d busy_cycles=%0d, required 0 and 0", log_q.size(), busy_cnt);
    end
  endtask

  task test_tick_sweep;
    do_reset();
    pulse(1'b0, 5'b00100);
    wait_idle("sweep_setup");
    repeat (5) begin
      pulse(1'b1, 5'b00000);
      wait_idle("sweep_setup");
    end
    clear_log();
    pulse(1'b1, 5'b00000);
    wait_idle("sweep");
    add_block(80, 5, 3'b000);
    add_block(80, 6, 3'b110);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL sweep pixel_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL sweep pixel %0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (busy_cnt != 34 || active !== 5'b00100) begin
      fails++;
      $display("[TB] FAIL sweep state: got busy_cycles=%0d active=%b, required 34 and 00100", busy_cnt, active);
    end
  endtask

  task test_miss_bottom;
    do_reset();
    max_y = 0;
    pulse(1'b0, 5'b10000);
    wait_idle("miss_setup");
    repeat (116) begin
      pulse(1'b1, 5'b00000);
      wait_idle("miss_setup");
    end
    clear_log();
    pulse(1'b1, 5'b00000);
    wait_idle("miss");
    add_block(144, 116, 3'b000);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL miss pixel_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL miss pixel %0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (miss_cnt != 1 || active !== 5'b00000 || busy_cnt != 18) begin
      fails++;
      $display("[TB] FAIL miss state: got miss_cycles=%0d active=%b busy_cycles=%0d, required 1, 00000, 18",
               miss_cnt, active, busy_cnt);
    end
    checks++;
    if (max_y != 119) begin
      fails++;
      $display("[TB] FAIL miss max_y: got %0d required 119", max_y);
    end
  endtask

  task test_tick_priority;
    do_reset();
    pulse(1'b0, 5'b00001);
    wait_idle("prio_setup");
    pulse(1'b0, 5'b01000);
    wait_idle("prio_setup");
    clear_log();
    pulse(1'b1, 5'b00010);
    wait_idle("prio");
    add_block(16, 0, 3'b000);
    add_block(16, 1, 3'b010);
    add_block(112, 0, 3'b000);
    add_block(112, 1, 3'b001);
    add_block(48, 0, 3'b100);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL prio pixel_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL prio pixel %0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (active !== 5'b01011) begin
      fails++;
      $display("[TB] FAIL prio active: got %b required 01011", active);
    end
  endtask

  task test_back_to_back;
    do_reset();
    pulse(1'b0, 5'b00001);
    wait_idle("b2b_setup");
    clear_log();
    pulse(1'b1, 5'b00000);
    pulse(1'b1, 5'b00000);
    pulse(1'b1, 5'b00000);
    wait_idle("b2b");
    add_block(16, 0, 3'b000);
    add_block(16, 1, 3'b010);
    add_block(16, 1, 3'b000);
    add_block(16, 2, 3'b010);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL b2b pixel_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL b2b pixel %0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovr_cnt != 1 || busy_cnt != 68) begin
      fails++;
      $display("[TB] FAIL b2b state: got overrun_cycles=%0d busy_cycles=%0d, required 1 and 68", ovr_cnt, busy_cnt);
    end
  endtask

  task test_reset_mid_draw;
    do_reset();
    pulse(1'b0, 5'b00001);
    wait_idle("abort_setup");
    pulse(1'b1, 5'b00000);
    repeat (24) @(negedge clk);
    // DRAW is now at cnt 7; the visible pixel is the one plotted at cnt 6.
    checks++;
    if (plot !== 1'b1 || {x, y, colour} !== {8'd18, 7'd2, 3'b010}) begin
      fails++;
      $display("[TB] FAIL abort_pre: got plot=%b x=%0d y=%0d c=%b, required 1 18 2 010", plot, x, y, colour);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (plot !== 1'b0 || active !== 5'b00000 || busy !== 1'b0 || {x, y, colour} !== '0) begin
      fails++;
      $display("[TB] FAIL abort_async: got plot=%b active=%b busy=%b x=%0d y=%0d c=%b, required all 0",
               plot, active, busy, x, y, colour);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != 0 || busy_cnt != 0) begin
      fails++;
      $display("[TB] FAIL abort_quiet: got plots=%0d busy_cycles=%0d, required 0 and 0", log_q.size(), busy_cnt);
    end
    pulse(1'b0, 5'b00001);
    wait_idle("abort_respawn");
    add_block(16, 0, 3'b010);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL abort_respawn pixel_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL abort_respawn pixel %0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (active !== 5'b00001) begin
      fails++;
      $display("[TB] FAIL abort_respawn active: got %b required 00001", active);
    end
  endtask

  initial begin
    $display("[TB] starting note_lane_scheduler bench");
    test_reset();
    test_spawn_lane0();
    test_tick_sweep();
    test_miss_bottom();
    test_tick_priority();
    test_back_to_back();
    test_reset_mid_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
